cmd_pulse_gen: RTL and testbench
================================

Name: cmd_pulse_gen

Overview:
- Front-end conditioner directly upstream of the 5-bit up/down counter.
- Converts three raw push-buttons (up, down, load) and a 5-bit switch bank into the counter's command inputs: clean single-cycle `up`/`down`/`load` strobes plus a registered `in` value.
- Provides two-flop synchronisation, debounce, rising-edge pulse generation, auto-repeat for held up/down, and command arbitration.

Parameters:
- WIDTH, 5, width of switch bank and `in` output.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a level change (≥2).
- REPEAT_DELAY, 16, cycles from the first pulse to the first auto-repeat pulse while held.
- REPEAT_PERIOD, 4, cycles between subsequent auto-repeat pulses (≥2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_up  input  1  raw asynchronous up button, active high.
- btn_down  input  1  raw asynchronous down button, active high.
- btn_load  input  1  raw asynchronous load button, active high.
- sw_in  input  WIDTH  raw switch value to load.
- up  output  1  registered single-cycle increment strobe.
- down  output  1  registered single-cycle decrement strobe.
- load  output  1  registered single-cycle load strobe.
- in  output  WIDTH  registered load value, valid while `load`=1, held otherwise.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high.
  - While `rst`=1 at a clk edge, all sync flops, debounce counters, repeat timers and FSMs clear.
  - up=down=load=0; in=0.
  - A button held through reset is treated as a new press after release of reset (full debounce applies).
- Sync: each button passes through 2 flops. `sw_in` is not synchronised; it is sampled only on load capture.
- Debounce (per button): counter runs while synced level ≠ debounced level and clears when equal.
  - Debounced level flips when the mismatch persists DEBOUNCE_CYCLES consecutive cycles.
  - Glitches shorter than that produce nothing.
- Latency: a clean press sampled high at edge E0 gives the first strobe high in the cycle after edge E0+2+DEBOUNCE_CYCLES (6 with defaults). Strobe width is exactly 1 cycle.
- Up/down FSM (per button): IDLE → FIRST (emit pulse) → WAIT_DELAY → REPEAT → IDLE.
  - IDLE → FIRST on debounced rise.
  - FIRST → WAIT_DELAY, counting REPEAT_DELAY cycles.
  - WAIT_DELAY → REPEAT, emitting a pulse, then one pulse every REPEAT_PERIOD cycles.
  - Any state → IDLE on debounced fall, with no pulse on release.
- Load: one pulse per debounced rise, no auto-repeat.
  - At the edge that raises `load`, `in` ← `sw_in`.
  - `in` holds that value until the next load capture.
- Arbitration (registered, same cycle as strobes):
  - load candidate present: load=1, up=down=0.
  - else up and down candidates both present: up=down=0; both candidates dropped, not deferred.
  - else the single candidate passes through.
  - Timers keep running regardless of suppression.
  - Outputs are never simultaneously high.
- Release during WAIT_DELAY/REPEAT stops further pulses immediately once debounced low.
- Timer widths are sized for the parameters; no wrap-around artefacts.

Test Plan:
- Reset with all buttons high, rst deasserted with buttons still held: all outputs 0 during reset. Exactly one up/down/load arbitration result appears 6 cycles after the first post-reset sampling edge (load wins: load=1, up=down=0).
- btn_up pulse high for 3 cycles then low (glitch < DEBOUNCE_CYCLES): up stays 0 throughout.
- btn_up held 40 cycles, defaults: up pulses at relative cycles 6, 22, 26, 30, 34, 38 (relative to first high sample, ±debounce on release). No pulse after release is debounced.
- sw_in=5'b10110, btn_load pressed 10 cycles: one load pulse with in=5'b10110 in the same cycle. Change sw_in to 5'b00011 afterwards: in stays 5'b10110.
- btn_up and btn_down pressed on the same edge: no up/down pulse at cycle 6. During repeat, pulses coinciding on the same cycle are suppressed; non-coinciding ones pass.
- btn_down held repeating, btn_load pressed so load's first pulse lands on a down repeat cycle: load=1, down=0 that cycle. Down repeat cadence is unchanged afterward.

Source files
------------

// File: rtl/cmd_pulse_gen.sv
// Button front-end for the 5-bit up/down counter: sync, debounce, edge/auto-repeat, arbitration.
// Latency: strobe registered 2+DEBOUNCE_CYCLES cycles after the first high sample of a clean press.
// Backpressure: none; strobes are fire-and-forget, suppressed candidates are dropped, not queued.

// Two-flop synchroniser followed by a consecutive-cycle debounce filter for one button.
module cmd_pulse_gen_deb #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic deb_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count mismatching cycles; flip the accepted level once the mismatch has lasted long enough.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser and debounce state; reset clears everything so a held button re-debounces.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

// Auto-repeat sequencer for a debounced up/down button; pulse_o is the unregistered candidate.
module cmd_pulse_gen_rpt #(
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic deb_i,
    output logic pulse_o
);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_REPEAT = 2'd3;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic          pulse;

    // The timer holds the number of cycles since the last emitted pulse (1 on the pulse edge itself).
    // A debounced release wins over any pending pulse, so nothing fires once the release is accepted.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pulse   = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (deb_i) begin
                    pulse   = 1'b1;
                    state_d = S_FIRST;
                    tmr_d   = TW'(1);
                end
            end
            S_FIRST: begin
                if (!deb_i) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else begin
                    state_d = S_WAIT;
                    tmr_d   = tmr_q + TW'(1);
                end
            end
            S_WAIT: begin
                if (!deb_i) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else if (tmr_q >= TW'(REPEAT_DELAY)) begin
                    pulse   = 1'b1;
                    state_d = S_REPEAT;
                    tmr_d   = TW'(1);
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                if (!deb_i) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else if (tmr_q >= TW'(REPEAT_PERIOD)) begin
                    pulse = 1'b1;
                    tmr_d = TW'(1);
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
        endcase
    end

    // Sequencer state and repeat timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    assign pulse_o = pulse;
endmodule

// Top: three conditioned buttons, load edge detect, arbitration and registered command outputs.
module cmd_pulse_gen #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] sw_in,
    output logic             up,
    output logic             down,
    output logic             load,
    output logic [WIDTH-1:0] in
);
    logic             up_deb;
    logic             down_deb;
    logic             load_deb;
    logic             up_cand;
    logic             down_cand;
    logic             load_cand;
    logic             load_seen_q;
    logic             up_q;
    logic             down_q;
    logic             load_q;
    logic             up_d;
    logic             down_d;
    logic             load_d;
    logic [WIDTH-1:0] in_q;

    cmd_pulse_gen_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk(clk), .rst(rst), .btn_i(btn_up), .deb_o(up_deb)
    );
    cmd_pulse_gen_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk(clk), .rst(rst), .btn_i(btn_down), .deb_o(down_deb)
    );
    cmd_pulse_gen_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_load (
        .clk(clk), .rst(rst), .btn_i(btn_load), .deb_o(load_deb)
    );

    cmd_pulse_gen_rpt #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rpt_up (
        .clk(clk), .rst(rst), .deb_i(up_deb), .pulse_o(up_cand)
    );
    cmd_pulse_gen_rpt #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rpt_down (
        .clk(clk), .rst(rst), .deb_i(down_deb), .pulse_o(down_cand)
    );

    // Load fires once per debounced rise; no auto-repeat.
    assign load_cand = load_deb & ~load_seen_q;

    // Load beats everything; coincident up+down cancel each other and are simply lost.
    always_comb begin
        up_d   = 1'b0;
        down_d = 1'b0;
        load_d = 1'b0;
        if (load_cand) begin
            load_d = 1'b1;
        end else if (!(up_cand && down_cand)) begin
            up_d   = up_cand;
            down_d = down_cand;
        end
    end

    // Registered strobes; the switch bank is sampled only on the edge that raises load.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_seen_q <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            load_q      <= 1'b0;
            in_q        <= '0;
        end else begin
            load_seen_q <= load_deb;
            up_q        <= up_d;
            down_q      <= down_d;
            load_q      <= load_d;
            if (load_cand) begin
                in_q <= sw_in;
            end
        end
    end

    assign up   = up_q;
    assign down = down_q;
    assign load = load_q;
    assign in   = in_q;
endmodule

// File: tb/tb_cmd_pulse_gen.sv
// Directed bench for cmd_pulse_gen with default parameters.
// Relative cycle i = outputs seen just after the i-th edge from the first high sample.
// Strobes appear at i = 6 and then every repeat interval while the debounced level stays high.
module tb_cmd_pulse_gen;
    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_load;
    logic [4:0] sw_in;
    logic       up;
    logic       down;
    logic       load;
    logic [4:0] in_o;

    int total;
    int bad;

    cmd_pulse_gen dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .sw_in(sw_in),
        .up(up), .down(down), .load(load), .in(in_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_gap();
        btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_up = 1'b1; btn_down = 1'b1; btn_load = 1'b1; sw_in = 5'b01001;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if ({up, down, load} !== 3'b000 || in_o !== 5'b00000) begin
                bad++;
                $display("FAIL reset_state: up=%b down=%b load=%b in=%b, expected 0 0 0 00000", up, down, load, in_o);
            end
        end
        rst = 1'b0;
        // Both up and down always coincide, load wins once at i=6.
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk); #1;
            total++;
            if (load !== (i == 6) || up !== 1'b0 || down !== 1'b0) begin
                bad++;
                $display("FAIL reset_held i=%0d: up=%b down=%b load=%b, expected 0 0 %b", i, up, down, load, (i == 6));
            end
            if (i == 6) begin
                total++;
                if (in_o !== 5'b01001) begin
                    bad++;
                    $display("FAIL reset_held_in: in=%b, expected 01001", in_o);
                end
            end
        end
        idle_gap();
    endtask

    task automatic test_glitch();
        btn_up = 1'b1;
        for (int i = 0; i <= 24; i++) begin
            @(posedge clk); #1;
            total++;
            if ({up, down, load} !== 3'b000) begin
                bad++;
                $display("FAIL glitch i=%0d: up=%b down=%b load=%b, expected 0 0 0", i, up, down, load);
            end
            if (i == 2) btn_up = 1'b0;
        end
        idle_gap();
    endtask

    // High for 40 samples: debounced low only at i=45, so the i=42 repeat still fires.
    task automatic test_hold_repeat();
        logic e;
        btn_up = 1'b1;
        for (int i = 0; i <= 60; i++) begin
            @(posedge clk); #1;
            e = (i == 6) || (i >= 22 && i <= 42 && ((i - 22) % 4) == 0);
            total++;
            if (up !== e || down !== 1'b0 || load !== 1'b0) begin
                bad++;
                $display("FAIL hold_repeat i=%0d: up=%b down=%b load=%b, expected %b 0 0", i, up, down, load, e);
            end
            if (i == 39) btn_up = 1'b0;
        end
        idle_gap();
    endtask

    task automatic test_load();
        logic [4:0] e_in;
        sw_in = 5'b10110; btn_load = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            @(posedge clk); #1;
            e_in = (i >= 6) ? 5'b10110 : 5'b01001;
            total++;
            if (load !== (i == 6) || up !== 1'b0 || down !== 1'b0 || in_o !== e_in) begin
                bad++;
                $display("FAIL load i=%0d: load=%b up=%b down=%b in=%b, expected %b 0 0 %b", i, load, up, down, in_o, (i == 6), e_in);
            end
            if (i == 6) sw_in = 5'b00011;
            if (i == 9) btn_load = 1'b0;
        end
        idle_gap();
    endtask

    task automatic test_same_edge();
        btn_up = 1'b1; btn_down = 1'b1;
        for (int i = 0; i <= 45; i++) begin
            @(posedge clk); #1;
            total++;
            if ({up, down, load} !== 3'b000) begin
                bad++;
                $display("FAIL same_edge i=%0d: up=%b down=%b load=%b, expected 0 0 0", i, up, down, load);
            end
            if (i == 29) begin btn_up = 1'b0; btn_down = 1'b0; end
        end
        idle_gap();
    endtask

    // Down starts 4 samples after up: down first pulse at 10 stands alone, its repeats (26,30,..)
    // land on up's repeats and cancel; up keeps 6 and 22.
    task automatic test_offset();
        btn_up = 1'b1;
        for (int i = 0; i <= 70; i++) begin
            @(posedge clk); #1;
            total++;
            if (up !== (i == 6 || i == 22) || down !== (i == 10) || load !== 1'b0) begin
                bad++;
                $display("FAIL offset i=%0d: up=%b down=%b load=%b, expected %b %b 0", i, up, down, load, (i == 6 || i == 22), (i == 10));
            end
            if (i == 3) btn_down = 1'b1;
            if (i == 49) begin btn_up = 1'b0; btn_down = 1'b0; end
        end
        idle_gap();
    endtask

    // Load first sampled high at i=24 so its pulse lands on the down repeat at 30.
    task automatic test_load_over_down();
        logic       e_dn;
        logic [4:0] e_in;
        sw_in = 5'b11100; btn_down = 1'b1;
        for (int i = 0; i <= 70; i++) begin
            @(posedge clk); #1;
            e_dn = (i == 6) || (i >= 22 && i <= 54 && i != 30 && ((i - 22) % 4) == 0);
            e_in = (i >= 30) ? 5'b11100 : 5'b10110;
            total++;
            if (down !== e_dn || load !== (i == 30) || up !== 1'b0 || in_o !== e_in) begin
                bad++;
                $display("FAIL load_over_down i=%0d: down=%b load=%b up=%b in=%b, expected %b %b 0 %b", i, down, load, up, in_o, e_dn, (i == 30), e_in);
            end
            if (i == 23) btn_load = 1'b1;
            if (i == 33) btn_load = 1'b0;
            if (i == 49) btn_down = 1'b0;
        end
        idle_gap();
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0; sw_in = 5'b00000;
        test_reset();
        test_glitch();
        test_hold_repeat();
        test_load();
        test_same_edge();
        test_offset();
        test_load_over_down();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
